usb_packet_encoder: RTL and testbench
=====================================

# usb_packet_encoder

Transmit-side packet builder for the USB device link of the miner. It converts a send request (handshake or data packet with up to MAX_BYTES payload bytes) into a byte stream: SYNC, PID, payload, CRC16. It emits that stream over a valid/ready handshake to the downstream bit-stuff/NRZI serializer, then signals end-of-packet. It is the counterpart of the packet decoder. The mining controller uses it to return nonce/result data and ACK/NAK handshakes to the host.

## Interface
Parameters:
- MAX_BYTES, 16, payload buffer depth in bytes (≥9)
- LEN_W, 5, width of payload_len; must hold MAX_BYTES

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- send  in  1  start request, sampled only in IDLE
- pkt_type  in  2  00 ACK, 01 NAK, 10 DATA0, 11 DATA1
- payload  in  8*MAX_BYTES  payload bytes; byte k = payload[8k+7:8k], byte 0 sent first
- payload_len  in  LEN_W  payload byte count, 0..MAX_BYTES; ignored for ACK/NAK
- tx_ready  in  1  serializer can accept tx_data this cycle
- tx_data  out  8  current byte, LSB is first on the wire
- tx_valid  out  1  tx_data valid
- tx_eop  out  1  one-cycle pulse after the last byte is accepted
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP.
- Transfer: occurs on a rising edge where tx_valid && tx_ready. tx_data holds stable until it is transferred.
- IDLE: on send=1, latch pkt_type, payload and len, then go to SYNC. len is clamped to MAX_BYTES if larger. Initialise crc to 0xFFFF and the byte index to 0.
- SYNC: tx_data=0x80. On transfer, go to PID.
- PID: tx_data is ACK 0xD2, NAK 0x5A, DATA0 0xC3 or DATA1 0x4B. On transfer:
  - ACK/NAK go to EOP.
  - DATA with len=0 goes to CRC_LO.
  - Otherwise go to DATA.
- DATA: tx_data = latched byte[idx]. Each transfer updates crc over that byte and increments idx. The transfer of byte len-1 goes to CRC_LO.
- CRC algorithm (CRC-16/USB, reflected):
  - Per bit, LSB first: crc = (crc>>1) ^ ((crc[0]^bit) ? 0xA001 : 0).
  - All 8 bits of a byte are unrolled into a single cycle.
- CRC_LO: tx_data = ~crc[7:0]. CRC_HI: tx_data = ~crc[15:8]. The transfer in CRC_HI goes to EOP.
- EOP: tx_eop=1, tx_valid=0 for exactly one cycle, then IDLE.
- send while busy is ignored and not queued.
- Input changes after acceptance do not affect an in-flight packet.

## Timing
- Reset values: tx_data=0x00, tx_valid=0, tx_eop=0, busy=0, state IDLE, crc=0xFFFF.
- n_rst low at any edge, including mid-packet, returns the block to IDLE on that edge. Outputs take their reset values; no tx_eop is produced.
- send sampled high at edge N gives busy=1 and tx_valid=1 (SYNC) after edge N.
- With tx_ready held high, one byte transfers per cycle:
  - DATA packet: L+4 consecutive valid cycles.
  - ACK/NAK: 2 valid cycles.
  - Then 1 tx_eop cycle, then IDLE.
- With tx_ready low, the state, tx_data and crc all hold; there is no limit on stall length.
- tx_valid is 0 in IDLE and EOP. tx_data = 0x00 whenever tx_valid=0.
- The next send is accepted at the first edge in IDLE, which is the cycle after tx_eop.

## Test plan
- Reset mid-stream: assert n_rst=0 during DATA byte 3 -> all outputs at reset values after that edge; no tx_eop; a following ACK packet transmits normally.
- ACK with tx_ready=1 -> bytes 0x80, 0xD2 on consecutive cycles, then a single tx_eop pulse; busy high for exactly 3 cycles.
- DATA0, len=9, payload "123456789" (0x31..0x39), tx_ready=1 -> 0x80, 0xC3, 0x31..0x39, 0xC8, 0xB4, then tx_eop. CRC check value is 0xB4C8.
- DATA1, len=0 -> 0x80, 0x4B, 0x00, 0x00, then tx_eop.
- DATA0, len=4 (00 01 02 03) with tx_ready toggling pseudo-randomly -> same byte sequence as with tx_ready=1; tx_data stable through every stall; no byte duplicated or dropped.
- send pulsed while busy, plus payload changed mid-packet -> the in-flight packet is unchanged; no second packet starts unless send is high in IDLE.

Source files
------------

// File: rtl/usb_packet_encoder.sv
// usb_packet_encoder
// Transmit-side USB packet builder. Turns a send request (ACK/NAK handshake
// or DATA0/DATA1 with up to MAX_BYTES payload bytes) into the byte stream
// SYNC, PID, payload, CRC16. The stream goes out over a valid/ready handshake
// to the bit-stuff/NRZI serializer, followed by a one-cycle end-of-packet pulse.
//
// Ports:
//   clk          system clock, rising edge
//   n_rst        synchronous active-low reset
//   send         start request, only looked at while idle
//   pkt_type     00 ACK, 01 NAK, 10 DATA0, 11 DATA1
//   payload      payload bytes, byte k = payload[8k+7:8k], byte 0 first
//   payload_len  payload byte count (clamped to MAX_BYTES), ignored for ACK/NAK
//   tx_ready     serializer accepts tx_data this cycle
//   tx_data      current byte (LSB first on the wire), 0x00 when not valid
//   tx_valid     tx_data valid
//   tx_eop       one-cycle pulse after the last byte is accepted
//   busy         high whenever a packet is in flight
module usb_packet_encoder #(
  parameter int MAX_BYTES = 16,
  parameter int LEN_W     = 5
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   send,
  input  logic [1:0]             pkt_type,
  input  logic [8*MAX_BYTES-1:0] payload,
  input  logic [LEN_W-1:0]       payload_len,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  output logic                   tx_eop,
  output logic                   busy
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI, S_EOP
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             type_q;
  logic [8*MAX_BYTES-1:0] payload_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       idx_q;
  logic [15:0]            crc_q;
  logic [7:0]             cur_byte;
  logic                   accept;

  // CRC-16/USB, reflected: all eight bits of one byte folded in a single cycle.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ b[i]) ? 16'hA001 : 16'h0000);
    end
    return r;
  endfunction

  assign accept = (state_q == S_IDLE) && send;

  always_comb begin
    cur_byte = 8'h00;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (idx_q == LEN_W'(k)) cur_byte = payload_q[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request snapshot: the packet in flight is immune to later input changes.
  always_ff @(posedge clk) begin
    if (accept) begin
      type_q    <= pkt_type;
      payload_q <= payload;
      len_q     <= (payload_len > MAX_LEN) ? MAX_LEN : payload_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      crc_q <= 16'hFFFF;
      idx_q <= '0;
    end else if (accept) begin
      crc_q <= 16'hFFFF;
      idx_q <= '0;
    end else if (state_q == S_DATA && tx_ready) begin
      crc_q <= crc16_byte(crc_q, cur_byte);
      idx_q <= idx_q + LEN_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_eop   = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (send) state_d = S_SYNC;
      end
      S_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = 8'h80;
        if (tx_ready) state_d = S_PID;
      end
      S_PID: begin
        tx_valid = 1'b1;
        case (type_q)
          2'b00:   tx_data = 8'hD2;
          2'b01:   tx_data = 8'h5A;
          2'b10:   tx_data = 8'hC3;
          default: tx_data = 8'h4B;
        endcase
        if (tx_ready) begin
          if (!type_q[1])         state_d = S_EOP;
          else if (len_q == '0)   state_d = S_CRC_LO;
          else                    state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = cur_byte;
        if (tx_ready && (idx_q == len_q - LEN_W'(1))) state_d = S_CRC_LO;
      end
      S_CRC_LO: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q[7:0];
        if (tx_ready) state_d = S_CRC_HI;
      end
      S_CRC_HI: begin
        tx_valid = 1'b1;
        tx_data  = ~crc_q[15:8];
        if (tx_ready) state_d = S_EOP;
      end
      S_EOP: begin
        tx_eop  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_packet_encoder.sv
// tb_usb_packet_encoder
// Self-checking bench for usb_packet_encoder: directed vector table, hand-written
// reset/busy sequences and randomized packets against a byte-stream reference model.
module tb_usb_packet_encoder;

  localparam int MB = 16;
  localparam int LW = 5;

  logic          tb_clk = 1'b0;
  logic          n_rst;
  logic          send;
  logic [1:0]    pkt_type;
  logic [8*MB-1:0] payload;
  logic [LW-1:0] payload_len;
  logic          tx_ready;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_eop;
  logic          busy;

  always #5 tb_clk = ~tb_clk;

  usb_packet_encoder #(.MAX_BYTES(MB), .LEN_W(LW)) dut (
    .clk(tb_clk), .n_rst(n_rst), .send(send), .pkt_type(pkt_type),
    .payload(payload), .payload_len(payload_len), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_eop(tx_eop), .busy(busy)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0]      t;
    logic [LW-1:0]   len;
    logic [8*MB-1:0] pl;
    int              rdy;
    logic [7:0]      pid;
    bit              chk_crc;
    logic [7:0]      crc_lo;
    logic [7:0]      crc_hi;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: the wire byte sequence of a packet, CRC computed over a flat bit list.
  task automatic build_expected(input logic [1:0] t, input logic [8*MB-1:0] pl,
                                input logic [LW-1:0] len);
    logic [7:0]  pid_tab[4];
    bit          bits[$];
    logic [7:0]  b;
    logic [15:0] crc;
    bit          fb;
    int          n;
    pid_tab = '{8'hD2, 8'h5A, 8'hC3, 8'h4B};
    exp_q.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back(pid_tab[t]);
    if (t[1]) begin
      n = (int'(len) > MB) ? MB : int'(len);
      for (int k = 0; k < n; k++) begin
        b = pl[8*k +: 8];
        exp_q.push_back(b);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
      end
      crc = 16'hFFFF;
      foreach (bits[i]) begin
        fb  = crc[0] ^ bits[i];
        crc = crc >> 1;
        if (fb) crc = crc ^ 16'hA001;
      end
      exp_q.push_back(~crc[7:0]);
      exp_q.push_back(~crc[15:8]);
    end
  endtask

  // Sends one packet, collects transferred bytes, checks protocol rules and content.
  task automatic run_pkt(input string tag, input logic [1:0] t, input logic [8*MB-1:0] pl,
                         input logic [LW-1:0] len, input int rdy_pct, input bit mischief);
    int         valid_cycles, busy_cycles, eop_cnt, stall_err, zero_err, bad_idx;
    bit         done, prev_stall, rdy;
    logic [7:0] prev_data;
    valid_cycles = 0; busy_cycles = 0; eop_cnt = 0; stall_err = 0; zero_err = 0;
    done = 0; prev_stall = 0; prev_data = 8'h00;
    build_expected(t, pl, len);
    got.delete();
    @(negedge tb_clk);
    pkt_type = t; payload = pl; payload_len = len; send = 1'b1; tx_ready = 1'b0;
    @(negedge tb_clk);
    send = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      if (busy) busy_cycles++;
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err++;
      if (!tx_valid && tx_data !== 8'h00) zero_err++;
      if (tx_eop) begin
        eop_cnt++;
        if (tx_valid) zero_err++;
      end
      rdy = ($urandom_range(99) < rdy_pct);
      tx_ready = rdy;
      if (tx_valid) valid_cycles++;
      if (tx_valid && rdy) got.push_back(tx_data);
      prev_stall = tx_valid && !rdy;
      prev_data  = tx_data;
      if (mischief) begin
        send        = tx_eop ? 1'b0 : 1'($urandom_range(1));
        payload     = {$urandom, $urandom, $urandom, $urandom};
        pkt_type    = 2'($urandom_range(3));
        payload_len = LW'($urandom_range(31));
      end
      if (tx_eop) done = 1;
      @(negedge tb_clk);
    end
    send = 1'b0;
    check({tag, " finished"}, done, 1);
    check({tag, " byte count"}, got.size(), exp_q.size());
    n_checks++;
    bad_idx = -1;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      if (bad_idx < 0 && got[i] !== exp_q[i]) bad_idx = i;
    end
    if (bad_idx >= 0) begin
      n_err++;
      $display("FAIL %s bytes: at index %0d actual=%h required=%h",
               tag, bad_idx, got[bad_idx], exp_q[bad_idx]);
    end
    check({tag, " eop pulses"}, eop_cnt, 1);
    check({tag, " busy cycles"}, busy_cycles, valid_cycles + 1);
    check({tag, " stall stability"}, stall_err, 0);
    check({tag, " idle data zero"}, zero_err, 0);
    if (rdy_pct >= 100) check({tag, " valid cycles"}, valid_cycles, exp_q.size());
    check({tag, " busy after eop"}, busy, 1'b0);
    check({tag, " valid after eop"}, tx_valid, 1'b0);
    tx_ready = 1'b1;
    @(negedge tb_clk);
    check({tag, " no restart"}, {busy, tx_valid, tx_eop}, 3'b000);
  endtask

  initial begin
    bit         found;
    int         quiet_err;
    logic [1:0] rt;
    int         rp;

    vecs[0] = '{2'b00, 5'd0, '0, 100, 8'hD2, 0, 8'h00, 8'h00};
    vecs[1] = '{2'b01, 5'd7, {32{4'hA}}, 100, 8'h5A, 0, 8'h00, 8'h00};
    vecs[2] = '{2'b10, 5'd9, 128'h39_38_37_36_35_34_33_32_31, 100, 8'hC3, 1, 8'hC8, 8'hB4};
    vecs[3] = '{2'b11, 5'd0, {32{4'h5}}, 100, 8'h4B, 1, 8'h00, 8'h00};
    vecs[4] = '{2'b10, 5'd4, 128'h03_02_01_00, 50, 8'hC3, 0, 8'h00, 8'h00};
    vecs[5] = '{2'b11, 5'd20, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 100, 8'h4B, 0, 8'h00, 8'h00};

    n_rst = 1'b0; send = 1'b0; tx_ready = 1'b0;
    pkt_type = 2'b00; payload = '0; payload_len = '0;
    repeat (3) @(negedge tb_clk);
    check("reset tx_data", tx_data, 8'h00);
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset tx_eop", tx_eop, 1'b0);
    check("reset busy", busy, 1'b0);
    n_rst = 1'b1;
    @(negedge tb_clk);

    for (int v = 0; v < 6; v++) begin
      run_pkt($sformatf("vec%0d", v), vecs[v].t, vecs[v].pl, vecs[v].len, vecs[v].rdy, 0);
      check($sformatf("vec%0d pid", v), (got.size() > 1) ? got[1] : 8'hXX, vecs[v].pid);
      if (vecs[v].chk_crc) begin
        check($sformatf("vec%0d crc lo", v), (got.size() >= 4) ? got[got.size()-2] : 8'hXX, vecs[v].crc_lo);
        check($sformatf("vec%0d crc hi", v), (got.size() >= 4) ? got[got.size()-1] : 8'hXX, vecs[v].crc_hi);
      end
    end

    // send pulsed and inputs scrambled while the packet is in flight
    run_pkt("busy-send", 2'b10, 128'h03_02_01_00, 5'd4, 100, 1);
    run_pkt("busy-send-stall", 2'b11, 128'h39_38_37_36_35_34_33_32_31, 5'd9, 40, 1);

    // reset during DATA byte 3
    @(negedge tb_clk);
    pkt_type = 2'b10; payload = 128'h39_38_37_36_35_34_33_32_31; payload_len = 5'd9;
    send = 1'b1; tx_ready = 1'b1;
    @(negedge tb_clk);
    send = 1'b0;
    found = 0;
    for (int c = 0; c < 12 && !found; c++) begin
      if (tx_valid && tx_data == 8'h34) found = 1;
      else @(negedge tb_clk);
    end
    check("midrst reach byte3", found, 1);
    n_rst = 1'b0;
    @(negedge tb_clk);
    check("midrst tx_data", tx_data, 8'h00);
    check("midrst tx_valid", tx_valid, 1'b0);
    check("midrst tx_eop", tx_eop, 1'b0);
    check("midrst busy", busy, 1'b0);
    n_rst = 1'b1;
    quiet_err = 0;
    repeat (3) begin
      @(negedge tb_clk);
      if (tx_eop || busy || tx_valid) quiet_err++;
    end
    check("midrst quiet", quiet_err, 0);
    run_pkt("post-rst ack", 2'b00, '0, 5'd0, 100, 0);

    for (int i = 0; i < 20; i++) begin
      rt = 2'($urandom_range(3));
      case ($urandom_range(2))
        0:       rp = 100;
        1:       rp = 60;
        default: rp = 25;
      endcase
      run_pkt($sformatf("rand%0d", i), rt, {$urandom, $urandom, $urandom, $urandom},
              LW'($urandom_range(18)), rp, 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
